// File: rtl/matu_arb_pkg.sv
// Shared types and constants for the matu arbiter.
package matu_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam int PERF_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: returns the first requesting index
// strictly after i_ptr, wrapping around; o_any flags that one was found.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    int w_idx;

    // Scan farthest-to-nearest so the nearest requester after the pointer wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (i_req[ID_W'(w_idx)]) begin
                o_idx = ID_W'(w_idx);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matu_arbiter.sv
// Shares one matu among NREQ requesters, one job at a time, round-robin.
// The owner keeps the matu from operand handshake until its result drains.
// Optional build macro: MATU_ARB_PERF_EN adds per-requester completed-job
// counters on o_perf_cnt; without it the port is tied to zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no owner; pick next requester after the rr pointer
// ARB_ISSUE | owner's operands presented to matu, waiting for pre handshake
// ARB_WAIT  | job issued, routing matu result to owner until post handshake
module matu_arbiter
    import matu_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int INA_ROWS = 3,
    parameter int INA_COLS = 9,
    parameter int INB_ROWS = 1,
    parameter int INB_COLS = 9,
    parameter int SA_ROWS  = 3,
    parameter int SA_COLS  = 1,
    parameter int IN_WIDTH = 8,
    parameter int C_WIDTH  = 16
) (
    input  logic                                                       i_clk,
    input  logic                                                       i_rst,
    input  logic [NREQ-1:0]                                            i_req_valid,
    output logic [NREQ-1:0]                                            o_req_ready,
    input  logic [NREQ-1:0][INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0]  i_a,
    input  logic [NREQ-1:0][INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0]  i_b,
    input  logic [NREQ-1:0][SA_COLS-1:0][SA_ROWS-1:0][IN_WIDTH-1:0]    i_d,
    output logic [NREQ-1:0]                                            o_rsp_valid,
    input  logic [NREQ-1:0]                                            i_rsp_ready,
    output logic [SA_COLS-1:0][SA_ROWS-1:0][C_WIDTH-1:0]               o_rsp_c,
    output logic                                                       o_m_pre_valid,
    input  logic                                                       i_m_pre_ready,
    output logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0]            o_m_a,
    output logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0]            o_m_b,
    output logic [SA_COLS-1:0][SA_ROWS-1:0][IN_WIDTH-1:0]              o_m_d,
    input  logic                                                       i_m_post_valid,
    output logic                                                       o_m_post_ready,
    input  logic [SA_COLS-1:0][SA_ROWS-1:0][C_WIDTH-1:0]               i_m_c,
    output logic                                                       o_busy,
    output logic [$clog2(NREQ)-1:0]                                    o_gnt_id,
    output logic [NREQ-1:0][PERF_W-1:0]                                o_perf_cnt
);

    localparam int ID_W = $clog2(NREQ);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic [ID_W-1:0] r_gnt;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_pick;
    logic            w_any;
    logic            w_post_hs;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    // State, grant and rr pointer; pointer only advances on a completed job.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_ptr   <= ID_W'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_any) begin
                r_gnt <= w_pick;
            end
            if (w_post_hs) begin
                r_ptr <= r_gnt;
            end
        end
    end

    // Next state plus grant-muxed handshakes and datapath; all outputs idle by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_post_hs      = 1'b0;
        o_req_ready    = '0;
        o_rsp_valid    = '0;
        o_rsp_c        = '0;
        o_m_pre_valid  = 1'b0;
        o_m_post_ready = 1'b0;
        o_m_a          = '0;
        o_m_b          = '0;
        o_m_d          = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                o_m_a         = i_a[r_gnt];
                o_m_b         = i_b[r_gnt];
                o_m_d         = i_d[r_gnt];
                o_m_pre_valid = i_req_valid[r_gnt];
                if (!i_req_valid[r_gnt]) begin
                    // Owner withdrew before matu took the job: drop ownership quietly.
                    w_state_nxt = ARB_IDLE;
                end else if (i_m_pre_ready) begin
                    o_req_ready[r_gnt] = 1'b1;
                    w_state_nxt        = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                o_m_a              = i_a[r_gnt];
                o_m_b              = i_b[r_gnt];
                o_m_d              = i_d[r_gnt];
                o_rsp_valid[r_gnt] = i_m_post_valid;
                o_m_post_ready     = i_rsp_ready[r_gnt];
                o_rsp_c            = i_m_c;
                if (i_m_post_valid && i_rsp_ready[r_gnt]) begin
                    w_post_hs   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign o_busy   = (r_state != ARB_IDLE);
    assign o_gnt_id = r_gnt;

`ifdef MATU_ARB_PERF_EN
    logic [NREQ-1:0][PERF_W-1:0] r_perf_cnt;

    // Completed-job counter per requester, wrapping naturally at 2^PERF_W.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_perf_cnt <= '0;
        end else if (w_post_hs) begin
            r_perf_cnt[r_gnt] <= r_perf_cnt[r_gnt] + PERF_W'(1);
        end
    end

    assign o_perf_cnt = r_perf_cnt;
`else
    assign o_perf_cnt = '0;
`endif

endmodule

// File: tb/tb_matu_arbiter.sv
// Directed scenarios followed by a random phase, every cycle checked
// against a transaction-level reference of the arbitration rules.
module tb_matu_arbiter;

    localparam int NREQ     = 4;
    localparam int INA_ROWS = 3;
    localparam int INA_COLS = 9;
    localparam int INB_ROWS = 1;
    localparam int INB_COLS = 9;
    localparam int SA_ROWS  = 3;
    localparam int SA_COLS  = 1;
    localparam int IN_WIDTH = 8;
    localparam int C_WIDTH  = 16;

    logic clk;
    logic rst;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ-1:0][INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0] a;
    logic [NREQ-1:0][INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0] b;
    logic [NREQ-1:0][SA_COLS-1:0][SA_ROWS-1:0][IN_WIDTH-1:0]   d;
    logic [SA_COLS-1:0][SA_ROWS-1:0][C_WIDTH-1:0] rsp_c, m_c;
    logic pre_valid, pre_ready, post_valid, post_ready, busy;
    logic [1:0] gnt_id;
    logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0] m_a;
    logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0] m_b;
    logic [SA_COLS-1:0][SA_ROWS-1:0][IN_WIDTH-1:0]   m_d;
    logic [NREQ-1:0][31:0] perf;

    int total = 0;
    int bad   = 0;

    // reference state
    int m_phase;        // 0 no owner, 1 offering job to matu, 2 awaiting result
    int m_own;
    int m_ptr;
    int m_gnt;
    logic [NREQ-1:0] m_acc_last;
    logic [31:0] m_cnt [NREQ];

    // snapshots of the last checked cycle
    logic [NREQ-1:0] s_req_ready, s_rsp_valid;
    logic s_pre_valid, s_post_ready, s_busy;
    int   s_gnt;
    int   obs_q[$];

    matu_arbiter dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_a            (a),
        .i_b            (b),
        .i_d            (d),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_c        (rsp_c),
        .o_m_pre_valid  (pre_valid),
        .i_m_pre_ready  (pre_ready),
        .o_m_a          (m_a),
        .o_m_b          (m_b),
        .o_m_d          (m_d),
        .i_m_post_valid (post_valid),
        .o_m_post_ready (post_ready),
        .i_m_c          (m_c),
        .o_busy         (busy),
        .o_gnt_id       (gnt_id),
        .o_perf_cnt     (perf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic rand_ops(input int r);
        for (int i = 0; i < INA_ROWS; i++)
            for (int j = 0; j < INA_COLS; j++) a[r][i][j] = IN_WIDTH'($urandom);
        for (int i = 0; i < INB_ROWS; i++)
            for (int j = 0; j < INB_COLS; j++) b[r][i][j] = IN_WIDTH'($urandom);
        for (int i = 0; i < SA_COLS; i++)
            for (int j = 0; j < SA_ROWS; j++) d[r][i][j] = IN_WIDTH'($urandom);
    endtask

    task automatic rand_c();
        for (int i = 0; i < SA_COLS; i++)
            for (int j = 0; j < SA_ROWS; j++) m_c[i][j] = C_WIDTH'($urandom);
    endtask

    task automatic model_edge();
        int p;
        m_acc_last = '0;
        if (!rst) begin
            m_phase = 0;
            m_ptr   = NREQ - 1;
            m_gnt   = 0;
            m_own   = 0;
            for (int r = 0; r < NREQ; r++) m_cnt[r] = 0;
        end else if (m_phase == 0) begin
            p = pick(req_valid, m_ptr);
            if (p >= 0) begin
                m_own   = p;
                m_gnt   = p;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!req_valid[m_own]) m_phase = 0;
            else if (pre_ready) begin
                m_acc_last[m_own] = 1'b1;
                m_phase = 2;
            end
        end else begin
            if (post_valid && rsp_ready[m_own]) begin
                m_ptr = m_own;
                m_cnt[m_own] = m_cnt[m_own] + 32'd1;
                m_phase = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] oh, e_rr, e_rv;
        logic e_pv, e_pr;
        logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0] e_a;
        logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0] e_b;
        logic [SA_COLS-1:0][SA_ROWS-1:0][IN_WIDTH-1:0]   e_d;
        logic [SA_COLS-1:0][SA_ROWS-1:0][C_WIDTH-1:0]    e_c;
        logic [31:0] e_cnt;
        oh = '0;
        oh[m_own] = 1'b1;
        e_pv = (m_phase == 1) && req_valid[m_own];
        e_rr = (e_pv && pre_ready) ? oh : '0;
        e_rv = (m_phase == 2 && post_valid) ? oh : '0;
        e_pr = (m_phase == 2) && rsp_ready[m_own];
        e_a  = (m_phase != 0) ? a[m_own] : '0;
        e_b  = (m_phase != 0) ? b[m_own] : '0;
        e_d  = (m_phase != 0) ? d[m_own] : '0;
        e_c  = (m_phase == 2) ? m_c : '0;
        chk("busy",       256'(busy),       256'(m_phase != 0));
        chk("gnt_id",     256'(gnt_id),     256'(m_gnt));
        chk("pre_valid",  256'(pre_valid),  256'(e_pv));
        chk("req_ready",  256'(req_ready),  256'(e_rr));
        chk("rsp_valid",  256'(rsp_valid),  256'(e_rv));
        chk("post_ready", 256'(post_ready), 256'(e_pr));
        chk("rsp_c",      256'(rsp_c),      256'(e_c));
        chk("m_a",        256'(m_a),        256'(e_a));
        chk("m_b",        256'(m_b),        256'(e_b));
        chk("m_d",        256'(m_d),        256'(e_d));
        for (int r = 0; r < NREQ; r++) begin
`ifdef MATU_ARB_PERF_EN
            e_cnt = m_cnt[r];
`else
            e_cnt = 32'd0;
`endif
            chk("perf_cnt", 256'(perf[r]), 256'(e_cnt));
        end
    endtask

    // Inputs are set just after a posedge; check mid-cycle, then advance.
    task automatic cyc();
        #1;
        check_outputs();
        s_req_ready  = req_ready;
        s_rsp_valid  = rsp_valid;
        s_pre_valid  = pre_valid;
        s_post_ready = post_ready;
        s_busy       = busy;
        s_gnt        = int'(gnt_id);
        for (int r = 0; r < NREQ; r++) if (req_ready[r]) obs_q.push_back(r);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int guard, n_pv, n_rr, jobs;
        int n_rsp [NREQ];
        int n_acc [NREQ];

        rst = 1'b0;
        req_valid = '0; rsp_ready = '0; pre_ready = 1'b0; post_valid = 1'b0;
        for (int r = 0; r < NREQ; r++) rand_ops(r);
        rand_c();
        @(posedge clk);
        model_edge();
        #1;

        // reset state, idle requesters
        cyc();
        chk("rst_busy", 256'(s_busy), 256'(0));
        chk("rst_gnt", 256'(s_gnt), 256'(0));
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("idle_req_ready", 256'(s_req_ready), 256'(0));
            chk("idle_pre_valid", 256'(s_pre_valid), 256'(0));
        end

        // all four requesting, two jobs each
        req_valid = 4'b1111; pre_ready = 1'b1; post_valid = 1'b1; rsp_ready = 4'b1111;
        obs_q.delete();
        for (int r = 0; r < NREQ; r++) begin n_rsp[r] = 0; n_acc[r] = 0; end
        guard = 0;
        while ((obs_q.size() < 8 || m_phase != 0) && guard < 100) begin
            rand_c();
            cyc();
            guard++;
            for (int r = 0; r < NREQ; r++) begin
                n_rsp[r] += int'(s_rsp_valid[r]);
                if (m_acc_last[r]) begin
                    n_acc[r]++;
                    if (n_acc[r] == 2) req_valid[r] = 1'b0;
                    else rand_ops(r);
                end
            end
        end
        chk("rr_timeout", 256'(guard < 100), 256'(1));
        chk("rr_jobs", 256'(obs_q.size()), 256'(8));
        for (int i = 0; i < 8 && i < obs_q.size(); i++) chk("rr_order", 256'(obs_q[i]), 256'(i % 4));
        for (int r = 0; r < NREQ; r++) chk("rr_rsp_count", 256'(n_rsp[r]), 256'(2));

        // req2 alone with matu stalling 5 cycles
        req_valid = 4'b0100; pre_ready = 1'b0; post_valid = 1'b0; rsp_ready = '0;
        rand_ops(2);
        cyc();
        n_pv = 0; n_rr = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_pv += int'(s_pre_valid);
            n_rr += int'(s_req_ready[2]);
        end
        pre_ready = 1'b1;
        cyc();
        n_rr += int'(s_req_ready[2]);
        chk("stall_accept", 256'(s_req_ready), 256'(4'b0100));
        req_valid = '0; pre_ready = 1'b0; post_valid = 1'b1; rsp_ready = 4'b0100;
        rand_c();
        cyc();
        n_rr += int'(s_req_ready[2]);
        chk("stall_pre_valid_cycles", 256'(n_pv), 256'(5));
        chk("stall_ready_pulses", 256'(n_rr), 256'(1));
        chk("stall_rsp", 256'(s_rsp_valid), 256'(4'b0100));

        // owner 1 back-pressures the result while req3 waits
        req_valid = 4'b0010; pre_ready = 1'b1; post_valid = 1'b0; rsp_ready = '0;
        cyc();
        cyc();
        chk("bp_gnt", 256'(s_gnt), 256'(1));
        chk("bp_accept", 256'(s_req_ready), 256'(4'b0010));
        req_valid = 4'b1000; post_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_c();
            cyc();
            chk("bp_post_ready", 256'(s_post_ready), 256'(0));
            chk("bp_busy", 256'(s_busy), 256'(1));
            chk("bp_req3_ready", 256'(s_req_ready), 256'(0));
        end
        rsp_ready = 4'b0010;
        cyc();
        chk("bp_release", 256'(s_post_ready), 256'(1));
        rsp_ready = '0; post_valid = 1'b0;
        cyc();
        cyc();
        chk("bp_next_gnt", 256'(s_gnt), 256'(3));
        chk("bp_next_accept", 256'(s_req_ready), 256'(4'b1000));
        req_valid = '0; post_valid = 1'b1; rsp_ready = 4'b1000;
        cyc();

        // withdrawal in ISSUE leaves the pointer where it was (3)
        req_valid = 4'b0010; pre_ready = 1'b0; post_valid = 1'b0; rsp_ready = '0;
        cyc();
        cyc();
        chk("wd_gnt", 256'(s_gnt), 256'(1));
        chk("wd_pre_valid", 256'(s_pre_valid), 256'(1));
        req_valid = '0;
        cyc();
        chk("wd_no_issue", 256'(s_pre_valid), 256'(0));
        req_valid = 4'b1111; pre_ready = 1'b1;
        cyc();
        cyc();
        chk("wd_next_gnt", 256'(s_gnt), 256'(0));
        chk("wd_next_accept", 256'(s_req_ready), 256'(4'b0001));

        // reset while waiting for a result
        req_valid = 4'b1110; post_valid = 1'b0;
        cyc();
        cyc();
        chk("midrst_busy_before", 256'(s_busy), 256'(1));
        rst = 1'b0; req_valid = '0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_busy", 256'(s_busy), 256'(0));
        chk("midrst_gnt", 256'(s_gnt), 256'(0));
        req_valid = 4'b1111; pre_ready = 1'b1; post_valid = 1'b1; rsp_ready = 4'b1111;
        cyc();
        cyc();
        chk("midrst_first_gnt", 256'(s_gnt), 256'(0));
        chk("midrst_first_accept", 256'(s_req_ready), 256'(4'b0001));
        req_valid = 4'b0001;
        jobs = 1;
        guard = 0;
        while ((jobs < 3 || m_phase != 0) && guard < 50) begin
            cyc();
            guard++;
            if (m_acc_last[0]) begin
                jobs++;
                if (jobs == 3) req_valid = '0;
            end
        end
        chk("perf_timeout", 256'(guard < 50), 256'(1));
        #1;
`ifdef MATU_ARB_PERF_EN
        chk("perf0_three", 256'(perf[0]), 256'(3));
`else
        chk("perf0_tied", 256'(perf[0]), 256'(0));
`endif

        // random traffic
        for (int cy = 0; cy < 400; cy++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (m_acc_last[r]) req_valid[r] = 1'b0;
                else if (!req_valid[r]) begin
                    if ($urandom_range(3) == 0) begin
                        req_valid[r] = 1'b1;
                        rand_ops(r);
                    end
                end else if ($urandom_range(31) == 0) req_valid[r] = 1'b0;
            end
            pre_ready  = 1'($urandom_range(1));
            post_valid = 1'($urandom_range(1));
            rsp_ready  = NREQ'($urandom);
            rand_c();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
